spi_master: RTL and testbench

Single-clock SPI master: the initiating end of the four-wire link answered by the slave block. It accepts a parallel word with a `start` strobe, generates `SCLK` and `SS`, shifts the word out on `MOSI`, and captures the returned word from `MISO` in one full-duplex transfer. Clock polarity, clock phase, bit order and word length are build-time parameters, so the master can be matched to any slave configuration.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 31 +++
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Imported by the master top and its SCLK divider.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    GAP
  } spi_state_e;

  localparam bit CPOL_LOW        = 1'b0;
  localparam bit CPOL_HIGH       = 1'b1;
  localparam bit CPHA_LEAD       = 1'b0;
  localparam bit CPHA_TRAIL      = 1'b1;
  localparam bit SHIFT_MSB_FIRST = 1'b0;
  localparam bit SHIFT_LSB_FIRST = 1'b1;

  localparam int unsigned DEFAULT_DATA_LENGTH = 8;
  localparam int unsigned DEFAULT_CLK_DIV     = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider for the SPI master.
// Pulses o_tick once every CLK_DIV cycles while enabled.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = i_en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master with build-time mode, order and length.
// LEAD/XFER/TRAIL frame the word; GAP guarantees SS high time.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_LENGTH     = DEFAULT_DATA_LENGTH,
  parameter int unsigned CLK_DIV         = DEFAULT_CLK_DIV,
  parameter bit          CPOL            = CPOL_LOW,
  parameter bit          CPHA            = CPHA_LEAD,
  parameter bit          SHIFT_DIRECTION = SHIFT_MSB_FIRST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic                   SS
);

  localparam int unsigned HW = $clog2(2 * DATA_LENGTH + 1);
  localparam logic [HW-1:0] HP_LAST = HW'(2 * DATA_LENGTH - 1);
  localparam bit LSB_FIRST = (SHIFT_DIRECTION == SHIFT_LSB_FIRST);
  localparam bit LATE = (CPHA == CPHA_TRAIL);

  spi_state_e r_state;
  spi_state_e w_next;

  logic [HW-1:0]          r_hp;
  logic [DATA_LENGTH-1:0] r_tx;
  logic [DATA_LENGTH-1:0] r_rx;
  logic [DATA_LENGTH-1:0] r_rx_data;
  logic                   r_sclk;
  logic                   r_mosi;
  logic                   r_done;

  logic w_tick;
  logic w_accept;
  logic w_last;
  logic w_edge;
  logic w_h_odd;
  logic w_launch;
  logic w_sample;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state != IDLE),
    .o_tick(w_tick)
  );

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_hp == HP_LAST);
  assign w_edge   = w_tick && ((r_state == LEAD) ||
                    ((r_state == XFER) && !w_last));
  // Parity of the half-period this edge opens: even = leading edge.
  assign w_h_odd  = (r_state == LEAD) ? 1'b0 : ~r_hp[0];
  assign w_launch = w_edge && (w_h_odd ^ LATE);
  assign w_sample = w_edge && !(w_h_odd ^ LATE);

  assign busy    = (r_state != IDLE);
  assign SS      = !(r_state inside {LEAD, XFER, TRAIL});
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;

  function automatic logic first_bit(
    input logic [DATA_LENGTH-1:0] w
  );
    return LSB_FIRST ? w[0] : w[DATA_LENGTH-1];
  endfunction

  function automatic logic [DATA_LENGTH-1:0] shift_out(
    input logic [DATA_LENGTH-1:0] w
  );
    return LSB_FIRST ? {1'b0, w[DATA_LENGTH-1:1]}
                     : {w[DATA_LENGTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = LEAD;
      LEAD:    if (w_tick) w_next = XFER;
      XFER:    if (w_tick && w_last) w_next = TRAIL;
      TRAIL:   if (w_tick) w_next = GAP;
      GAP:     if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_hp <= '0;
    end else if ((r_state == XFER) && w_tick) begin
      r_hp <= r_hp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk    <= CPOL;
      r_mosi    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // CPHA=0 must present bit 0 before the first SCLK edge.
      if (w_accept) begin
        r_tx <= LATE ? tx_data : shift_out(tx_data);
        if (!LATE) r_mosi <= first_bit(tx_data);
      end
      if (w_edge) r_sclk <= ~r_sclk;
      if (w_launch) begin
        r_mosi <= first_bit(r_tx);
        r_tx   <= shift_out(r_tx);
      end
      if (w_sample) begin
        r_rx <= LSB_FIRST ? {MISO, r_rx[DATA_LENGTH-1:1]}
                          : {r_rx[DATA_LENGTH-2:0], MISO};
      end
      if ((r_state == TRAIL) && w_tick) begin
        r_rx_data <= r_rx;
        r_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four mode variants against a cycle-count model.
// A slave model drives MISO; frame timing comes from the transfer age.
module tb_spi_master;

  localparam int DL = 8;
  localparam logic [3:0] POL = 4'b0010;
  localparam logic [3:0] PHA = 4'b1010;
  localparam logic [3:0] LSB = 4'b1100;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [7:0] txd [4];
  logic [7:0] mw [4];
  logic [3:0] miso = '0;

  wire [3:0] busy, done, sclk, mosi, ss;
  wire [7:0] rxd [4];

  int         age [4] = '{0, 0, 0, 0};
  logic [7:0] wtx [4];
  logic [7:0] wrx [4];
  logic [7:0] exp_rx [4] = '{0, 0, 0, 0};

  logic [7:0] col [4];
  int         sslen [4] = '{0, 0, 0, 0};
  int         fall_cyc [4] = '{0, 0, 0, 0};
  int         last_gap [4] = '{0, 0, 0, 0};
  int         hi_run [4] = '{0, 0, 0, 0};
  int         last_hi [4] = '{0, 0, 0, 0};
  int         done_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] prev_sclk = '0;
  logic [3:0] prev_ss = '1;
  int         cyc = 0;
  bit         armed = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master #(
      .DATA_LENGTH    (DL),
      .CLK_DIV        ((g == 2) ? 3 : 2),
      .CPOL           (POL[g]),
      .CPHA           (PHA[g]),
      .SHIFT_DIRECTION(LSB[g])
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
      .tx_data(txd[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .rx_data(rxd[g]),
      .SCLK   (sclk[g]),
      .MOSI   (mosi[g]),
      .MISO   (miso[g]),
      .SS     (ss[g])
    );
  end

  function automatic int cdv(input int g);
    return (g == 2) ? 3 : 2;
  endfunction

  // Bit j in transmission order of a word.
  function automatic logic nth(input int g, input logic [7:0] w,
                               input int j);
    return LSB[g] ? w[j] : w[7-j];
  endfunction

  task automatic check(input string nm, input int g,
                       input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] at cyc %0d: got %0h want %0h",
               nm, g, cyc, act, exp);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy != 4'h0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, busy, 0);
  endtask

  // Model: age = cycles since acceptance (0 = idle).
  initial forever begin
    @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      if (rst) begin
        age[g] = 0;
        exp_rx[g] = '0;
      end else if (age[g] == 0) begin
        if (start[g]) begin
          age[g] = 1;
          wtx[g] = txd[g];
          wrx[g] = mw[g];
        end
      end else if (age[g] == cdv(g) * (2 * DL + 3)) begin
        age[g] = 0;
      end else begin
        if (age[g] == cdv(g) * (2 * DL + 2)) exp_rx[g] = wrx[g];
        age[g] = age[g] + 1;
      end
    end
  end

  // Compare, slave MISO drive and edge bookkeeping.
  initial forever begin
    @(negedge clk);
    cyc++;
    for (int g = 0; g < 4; g++) begin
      int a, cd, h, hh, j, ph;
      logic lvl;
      a = age[g];
      cd = cdv(g);
      ph = int'(PHA[g]);
      h = (a >= cd + 1 && a <= cd * (2 * DL + 1)) ? (a - cd - 1) / cd : -1;
      if (armed) begin
        check("ss", g, ss[g], int'(!(a >= 1 && a <= cd * (2 * DL + 2))));
        check("busy", g, busy[g], int'(a != 0));
        check("done", g, done[g], int'(a == cd * (2 * DL + 2) + 1));
        check("sclk", g, sclk[g],
              (h >= 0) ? int'(POL[g] ^ (h % 2 == 0)) : int'(POL[g]));
        check("rx", g, rxd[g], exp_rx[g]);
        if (ph == 0 && a >= 1 && a <= cd)
          check("mosi_lead", g, mosi[g], nth(g, wtx[g], 0));
        if (h >= 0 && (h % 2) == ph)
          check("mosi", g, mosi[g], nth(g, wtx[g], h / 2));
      end
      if (a >= 1 && a <= cd * (2 * DL + 1)) begin
        hh = (a <= cd) ? -1 : (a - cd - 1) / cd;
        j = (hh + 1 - ph) / 2;
        if (j > 7) j = 7;
        if (j < 0) j = 0;
        miso[g] = nth(g, wrx[g], j);
      end else begin
        miso[g] = 1'b0;
      end
      lvl = !(POL[g] ^ PHA[g]);
      if (a == 1) col[g] = '0;
      else if (a != 0 && sclk[g] != prev_sclk[g] && sclk[g] == lvl)
        col[g] = {col[g][6:0], mosi[g]};
      prev_sclk[g] = sclk[g];
      if (!ss[g]) begin
        if (prev_ss[g]) begin
          last_gap[g] = cyc - fall_cyc[g];
          fall_cyc[g] = cyc;
          last_hi[g] = hi_run[g];
          sslen[g] = 0;
        end
        sslen[g]++;
        hi_run[g] = 0;
      end else begin
        hi_run[g]++;
      end
      prev_ss[g] = ss[g];
      if (done[g]) done_cnt[g]++;
    end
  end

  initial begin
    int d [4];
    rst = 1'b1;
    start = '0;
    for (int g = 0; g < 4; g++) begin
      txd[g] = '0;
      mw[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_ss", g, ss[g], 1);
      check("rst_sclk", g, sclk[g], int'(POL[g]));
      check("rst_mosi", g, mosi[g], 0);
      check("rst_busy", g, busy[g], 0);
      check("rst_done", g, done[g], 0);
      check("rst_rx", g, rxd[g], 0);
    end
    armed = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    txd = '{8'hA5, 8'h81, 8'h01, 8'hC3};
    mw  = '{8'h3C, 8'h7E, 8'h80, 8'h5A};
    start = 4'hF;
    @(negedge clk);
    start = 4'h0;
    wait_idle(200);
    check("lit_rx", 0, rxd[0], 8'h3C);
    check("lit_rx", 1, rxd[1], 8'h7E);
    check("lit_rx", 2, rxd[2], 8'h80);
    check("lit_rx", 3, rxd[3], 8'h5A);
    check("lit_mosi", 0, col[0], 8'hA5);
    check("lit_mosi", 1, col[1], 8'h81);
    check("lit_mosi", 2, col[2], 8'h80);
    check("lit_mosi", 3, col[3], 8'hC3);
    check("lit_sslen", 0, sslen[0], 36);
    check("lit_sslen", 1, sslen[1], 36);
    check("lit_sslen", 2, sslen[2], 54);
    check("lit_idle_sclk", 1, sclk[1], 1);

    start = 4'hF;
    repeat (130) @(negedge clk);
    start = 4'h0;
    wait_idle(200);
    check("lit_restart", 0, last_gap[0], 39);
    check("lit_ss_high", 0, last_hi[0], 3);
    check("lit_restart", 2, last_gap[2], 58);
    check("lit_ss_high", 2, last_hi[2], 4);

    txd = '{8'h5F, 8'h33, 8'hF0, 8'h0F};
    start = 4'hF;
    @(negedge clk);
    start = 4'h0;
    repeat (13) @(negedge clk);
    for (int g = 0; g < 4; g++) d[g] = done_cnt[g];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check("mid_rst_ss", g, ss[g], 1);
      check("mid_rst_sclk", g, sclk[g], int'(POL[g]));
      check("mid_rst_busy", g, busy[g], 0);
      check("mid_rst_rx", g, rxd[g], 0);
    end
    repeat (80) @(negedge clk);
    for (int g = 0; g < 4; g++)
      check("mid_rst_nodone", g, done_cnt[g], d[g]);

    for (int i = 0; i < 600; i++) begin
      for (int g = 0; g < 4; g++) begin
        start[g] = ($urandom_range(0, 7) == 0);
        txd[g] = 8'($urandom);
        mw[g] = 8'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 4'h0;
    rst = 1'b0;
    wait_idle(200);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
